// File: rtl/mcu_bus_sync.sv
// Clocked front end turning asynchronous 8-bit MCU bus strobes into single-cycle 16-bit register-file accesses.
// Optional read/write watchdog enabled by defining BUS_TIMEOUT_EN.
module mcu_bus_sync #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mcu_nsel,
    input  logic                  mcu_nrd,
    input  logic                  mcu_nwr,
    input  logic [ADDR_WIDTH:0]   mcu_addr,
    input  logic [7:0]            mcu_wdata,
    output logic [7:0]            mcu_rdata,
    output logic                  mcu_rdata_oe,
    output logic                  reg_en,
    output logic                  reg_rd,
    output logic                  reg_wr,
    output logic [1:0]            reg_be,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  bus_error
);

    // Two byte lanes are hard-wired; a zero watchdog limit would never let an access run.
    if (DATA_WIDTH != 16 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("mcu_bus_sync: DATA_WIDTH must be 16 and TIMEOUT_CYCLES nonzero");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_COMMIT,
        S_DRAIN
    } state_t;

    state_t                r_state;
    logic                  r_nsel_p1, r_nsel_s;
    logic                  r_nrd_p1,  r_nrd_s;
    logic                  r_nwr_p1,  r_nwr_s;
    logic [ADDR_WIDTH:0]   r_addr_p1, r_addr_s;
    logic [7:0]            r_wdata_p1, r_wdata_s;
    logic                  r_rd_d, r_wr_d;
    logic                  r_rd_lane;
    logic [ADDR_WIDTH:0]   r_waddr;
    logic [7:0]            r_wbyte;
    logic [7:0]            r_rhold;
    logic                  r_oe;
    logic                  r_reg_en, r_reg_rd, r_reg_wr;
    logic [1:0]            r_reg_be;
    logic [ADDR_WIDTH-1:0] r_reg_addr;
    logic [DATA_WIDTH-1:0] r_reg_wdata;
    logic                  r_bus_error;

    logic w_rd_s, w_wr_s, w_rd_rise, w_wr_rise, w_tmo_hit;

    assign w_rd_s    = ~r_nsel_s & ~r_nrd_s;
    assign w_wr_s    = ~r_nsel_s & ~r_nwr_s;
    assign w_rd_rise = w_rd_s & ~r_rd_d;
    assign w_wr_rise = w_wr_s & ~r_wr_d;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Dwell counter, restarted on every entry into READ or WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_READ || r_state == S_WRITE) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    // Synchronisers, access FSM and registered register-file / pad outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_DRAIN;
            r_nsel_p1   <= 1'b0;
            r_nsel_s    <= 1'b0;
            r_nrd_p1    <= 1'b0;
            r_nrd_s     <= 1'b0;
            r_nwr_p1    <= 1'b0;
            r_nwr_s     <= 1'b0;
            r_addr_p1   <= '0;
            r_addr_s    <= '0;
            r_wdata_p1  <= '0;
            r_wdata_s   <= '0;
            r_rd_d      <= 1'b0;
            r_wr_d      <= 1'b0;
            r_rd_lane   <= 1'b0;
            r_waddr     <= '0;
            r_wbyte     <= '0;
            r_rhold     <= '0;
            r_oe        <= 1'b0;
            r_reg_en    <= 1'b0;
            r_reg_rd    <= 1'b0;
            r_reg_wr    <= 1'b0;
            r_reg_be    <= '0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_bus_error <= 1'b0;
        end else begin
            r_nsel_p1  <= mcu_nsel;
            r_nsel_s   <= r_nsel_p1;
            r_nrd_p1   <= mcu_nrd;
            r_nrd_s    <= r_nrd_p1;
            r_nwr_p1   <= mcu_nwr;
            r_nwr_s    <= r_nwr_p1;
            r_addr_p1  <= mcu_addr;
            r_addr_s   <= r_addr_p1;
            r_wdata_p1 <= mcu_wdata;
            r_wdata_s  <= r_wdata_p1;
            r_rd_d     <= w_rd_s;
            r_wr_d     <= w_wr_s;
            r_reg_en   <= 1'b0;
            r_reg_rd   <= 1'b0;
            r_reg_wr   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_rd_rise && w_wr_rise) begin
                        r_bus_error <= 1'b1;
                        r_state     <= S_DRAIN;
                    end else if (w_rd_rise && !w_wr_s) begin
                        r_state    <= S_READ;
                        r_reg_en   <= 1'b1;
                        r_reg_rd   <= 1'b1;
                        r_reg_addr <= r_addr_s[ADDR_WIDTH:1];
                        r_rd_lane  <= r_addr_s[0];
                        r_oe       <= 1'b1;
                    end else if (w_wr_rise && !w_rd_s) begin
                        r_state <= S_WRITE;
                        r_waddr <= r_addr_s;
                        r_wbyte <= r_wdata_s;
                    end
                end
                S_READ: begin
                    // reg_rdata follows reg_addr combinationally, so capture while reg_rd is high.
                    if (r_reg_rd) begin
                        r_rhold <= r_rd_lane ? reg_rdata[15:8] : reg_rdata[7:0];
                    end
                    if (!w_rd_s) begin
                        r_state <= S_IDLE;
                        r_oe    <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_bus_error <= 1'b1;
                        r_state     <= S_DRAIN;
                        r_oe        <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (!w_wr_s) begin
                        r_state     <= S_COMMIT;
                        r_reg_en    <= 1'b1;
                        r_reg_wr    <= 1'b1;
                        r_reg_addr  <= r_waddr[ADDR_WIDTH:1];
                        r_reg_be    <= r_waddr[0] ? 2'b10 : 2'b01;
                        r_reg_wdata <= {r_wbyte, r_wbyte};
                    end else if (w_tmo_hit) begin
                        r_bus_error <= 1'b1;
                        r_state     <= S_DRAIN;
                    end else begin
                        r_waddr <= r_addr_s;
                        r_wbyte <= r_wdata_s;
                    end
                end
                S_COMMIT: r_state <= S_IDLE;
                S_DRAIN: begin
                    if (!w_rd_s && !w_wr_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_DRAIN;
            endcase
        end
    end

    assign mcu_rdata    = r_rhold;
    assign mcu_rdata_oe = r_oe;
    assign reg_en       = r_reg_en;
    assign reg_rd       = r_reg_rd;
    assign reg_wr       = r_reg_wr;
    assign reg_be       = r_reg_be;
    assign reg_addr     = r_reg_addr;
    assign reg_wdata    = r_reg_wdata;
    assign bus_error    = r_bus_error;

endmodule

// File: tb/tb_mcu_bus_sync.sv
// Bench for mcu_bus_sync: directed scenarios plus randomized MCU byte accesses against a byte-level memory model.
module tb_mcu_bus_sync;

    localparam int unsigned AW  = 8;
    localparam int unsigned TMO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          mcu_nsel, mcu_nrd, mcu_nwr;
    logic [AW:0]   mcu_addr;
    logic [7:0]    mcu_wdata;
    logic [7:0]    mcu_rdata;
    logic          mcu_rdata_oe;
    logic          reg_en, reg_rd, reg_wr;
    logic [1:0]    reg_be;
    logic [AW-1:0] reg_addr;
    logic [15:0]   reg_wdata;
    logic [15:0]   reg_rdata;
    logic          bus_error;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mcu_bus_sync #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (16),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mcu_nsel     (mcu_nsel),
        .mcu_nrd      (mcu_nrd),
        .mcu_nwr      (mcu_nwr),
        .mcu_addr     (mcu_addr),
        .mcu_wdata    (mcu_wdata),
        .mcu_rdata    (mcu_rdata),
        .mcu_rdata_oe (mcu_rdata_oe),
        .reg_en       (reg_en),
        .reg_rd       (reg_rd),
        .reg_wr       (reg_wr),
        .reg_be       (reg_be),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_rdata    (reg_rdata),
        .bus_error    (bus_error)
    );

    function automatic logic [15:0] init_word(input int i);
        if (i == 18) return 16'hBEEF;
        return 16'(i * 40503) ^ 16'h5A5A;
    endfunction

    // Register file behind the DUT, reloaded with known contents on every reset.
    logic [15:0] mem [256];
    assign reg_rdata = mem[reg_addr];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (reg_wr) begin
            if (reg_be[0]) mem[reg_addr][7:0]  <= reg_wdata[7:0];
            if (reg_be[1]) mem[reg_addr][15:8] <= reg_wdata[15:8];
        end
    end

    // Pulse monitor.
    int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
    logic [7:0]  last_wr_addr, last_rd_addr;
    logic [1:0]  last_wr_be;
    logic [15:0] last_wr_data;

    always @(negedge clk) begin
        if (reg_wr && reg_en) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= reg_addr;
            last_wr_be   <= reg_be;
            last_wr_data <= reg_wdata;
        end
        if (reg_rd && reg_en) begin
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= reg_addr;
        end
        if (reg_rd && reg_wr) both_cnt <= both_cnt + 1;
    end

    // Expected register-file contents as seen from the MCU side.
    logic [15:0] model [256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_neg(3);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) model[i] = init_word(i);
        wait_neg(4);
    endtask

    function automatic logic [7:0] model_byte(input logic [8:0] a);
        logic [15:0] w;
        w = model[a[8:1]];
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    // MCU write; data switches from d0 to d1 'sw' clocks before nwr rises.
    task automatic mcu_write(input logic [8:0] a, input logic [7:0] d0, input logic [7:0] d1,
                             input int hold, input int sw);
        int wc0, rc0;
        wc0 = wr_cnt;
        rc0 = rd_cnt;
        mcu_addr  = a;
        mcu_wdata = d0;
        mcu_nsel  = 1'b0;
        wait_neg(1);
        mcu_nwr = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (i == hold - sw) mcu_wdata = d1;
            wait_neg(1);
        end
        mcu_nwr = 1'b1;
        wait_neg(1);
        mcu_nsel = 1'b1;
        wait_neg(6);
        check("wr_pulses", 32'(wr_cnt - wc0), 32'd1);
        check("wr_no_rd", 32'(rd_cnt - rc0), 32'd0);
        check("wr_addr", 32'(last_wr_addr), 32'(a[8:1]));
        check("wr_be", 32'(last_wr_be), a[0] ? 32'd2 : 32'd1);
        check("wr_data", 32'(last_wr_data), 32'({d1, d1}));
        if (a[0]) model[a[8:1]][15:8] = d1;
        else      model[a[8:1]][7:0]  = d1;
    endtask

    task automatic mcu_read(input logic [8:0] a, input int hold);
        int rc0, wc0, n;
        rc0 = rd_cnt;
        wc0 = wr_cnt;
        mcu_addr = a;
        mcu_nsel = 1'b0;
        wait_neg(1);
        mcu_nrd = 1'b0;
        wait_neg(hold);
        check("rd_data", 32'(mcu_rdata), 32'(model_byte(a)));
        check("rd_oe", 32'(mcu_rdata_oe), 32'd1);
        mcu_nrd = 1'b1;
        n = 0;
        while (mcu_rdata_oe && n < 6) begin
            wait_neg(1);
            n++;
        end
        check("rd_oe_drop", 32'(n <= 3 && !mcu_rdata_oe), 32'd1);
        mcu_nsel = 1'b1;
        wait_neg(4);
        check("rd_pulses", 32'(rd_cnt - rc0), 32'd1);
        check("rd_no_wr", 32'(wr_cnt - wc0), 32'd0);
        check("rd_addr", 32'(last_rd_addr), 32'(a[8:1]));
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rc0, wc0;
        logic [8:0] a;
        logic [7:0] d;
        mcu_nsel  = 1'b1;
        mcu_nrd   = 1'b1;
        mcu_nwr   = 1'b1;
        mcu_addr  = '0;
        mcu_wdata = '0;
        do_reset();

        check("rst_oe", 32'(mcu_rdata_oe), 32'd0);
        check("rst_rdata", 32'(mcu_rdata), 32'd0);
        check("rst_en", 32'(reg_en), 32'd0);
        check("rst_err", 32'(bus_error), 32'd0);
        check("rst_no_access", 32'(rd_cnt + wr_cnt), 32'd0);

        mcu_read(9'h025, 8);
        check("read_0x25_be", 32'(mcu_rdata), 32'hBE);
        mcu_write(9'h024, 8'h5A, 8'h5A, 6, 6);
        mcu_write(9'h025, 8'h5A, 8'h5A, 6, 6);
        mcu_read(9'h024, 6);
        mcu_write(9'h040, 8'h11, 8'h77, 8, 4);
        mcu_read(9'h040, 5);

        // Both strobes at once.
        rc0 = rd_cnt;
        wc0 = wr_cnt;
        mcu_addr = 9'h031;
        mcu_nsel = 1'b0;
        wait_neg(1);
        mcu_nrd = 1'b0;
        mcu_nwr = 1'b0;
        wait_neg(6);
        mcu_nrd = 1'b1;
        mcu_nwr = 1'b1;
        wait_neg(1);
        mcu_nsel = 1'b1;
        wait_neg(6);
        check("both_no_rd", 32'(rd_cnt - rc0), 32'd0);
        check("both_no_wr", 32'(wr_cnt - wc0), 32'd0);
        check("both_err", 32'(bus_error), 32'd1);
        mcu_read(9'h031, 6);
        check("err_sticky", 32'(bus_error), 32'd1);
        do_reset();
        check("err_cleared", 32'(bus_error), 32'd0);

        // Reset pulse in the middle of a write.
        wc0 = wr_cnt;
        mcu_addr  = 9'h030;
        mcu_wdata = 8'hC3;
        mcu_nsel  = 1'b0;
        wait_neg(1);
        mcu_nwr = 1'b0;
        wait_neg(6);
        reset = 1'b1;
        wait_neg(2);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) model[i] = init_word(i);
        wait_neg(6);
        mcu_nwr = 1'b1;
        wait_neg(1);
        mcu_nsel = 1'b1;
        wait_neg(6);
        check("rstmid_no_wr", 32'(wr_cnt - wc0), 32'd0);
        check("rstmid_err", 32'(bus_error), 32'd0);
        mcu_write(9'h030, 8'hC3, 8'hC3, 5, 5);
        mcu_read(9'h030, 5);

        for (int k = 0; k < 40; k++) begin
            a = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 15)) : 9'($urandom);
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 0) mcu_write(a, d, d, $urandom_range(3, 10), 0);
            else                           mcu_read(a, $urandom_range(5, 10));
        end

`ifdef BUS_TIMEOUT_EN
        do_reset();
        wc0 = wr_cnt;
        mcu_addr  = 9'h050;
        mcu_wdata = 8'h99;
        mcu_nsel  = 1'b0;
        wait_neg(1);
        mcu_nwr = 1'b0;
        wait_neg(10);
        check("tmo_early", 32'(bus_error), 32'd0);
        wait_neg(30);
        check("tmo_err", 32'(bus_error), 32'd1);
        mcu_nwr = 1'b1;
        wait_neg(1);
        mcu_nsel = 1'b1;
        wait_neg(6);
        check("tmo_no_wr", 32'(wr_cnt - wc0), 32'd0);
`else
        mcu_write(9'h051, 8'h3C, 8'h3C, 40, 0);
        check("long_wr_err", 32'(bus_error), 32'd0);
        mcu_read(9'h051, 5);
`endif

        check("rd_wr_overlap", 32'(both_cnt), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
